instr_fetch_reader: RTL

- Consumer of the program counter stream: accepts PC values over a valid/ready handshake and reads the addressed word from an internal program ROM.
- Returns the instruction, tagged with its PC, through an output FIFO.
- A write port loads program memory, so the block is the reader paired with the program loader/counter.
- Sits between the program counter and the decode stage.

---
 rtl/instr_fetch_reader.sv | 135 +++++++++++++
 1 files changed

// File: rtl/instr_fetch_reader.sv
// instr_fetch_reader: accepts PCs over valid/ready, reads the addressed word
// from a writable program memory and returns {instr, pc, oob, wrap} through
// a small output FIFO toward decode.
module instr_fetch_reader #(
   parameter int  DATA_W     = 32,
   parameter int  PC_W       = 32,
   parameter int  DEPTH      = 16,
   parameter int  FIFO_DEPTH = 4,
   localparam int AW         = $clog2(DEPTH)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [PC_W-1:0]   pc_in,
   input  logic              pc_valid,
   output logic              pc_ready,
   input  logic              prog_we,
   input  logic [AW-1:0]     prog_addr,
   input  logic [DATA_W-1:0] prog_data,
   output logic [DATA_W-1:0] instr_out,
   output logic [PC_W-1:0]   instr_pc,
   output logic              instr_oob,
   output logic              instr_wrap,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [31:0]       fetch_count
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [PC_W-1:0]   pc;
      logic              oob;
      logic              wrap;
   } entry_t;

   // program memory: no reset, survives grst so the loader need not re-run
   logic [DATA_W-1:0] mem [DEPTH];

   // read stage
   logic              s1_valid;
   entry_t            s1_ent;
   logic [PC_W-1:0]   last_pc;

   // output FIFO
   entry_t            fifo_mem [FIFO_DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [CW-1:0]     fifo_count;

   logic              accept;
   logic              push;
   logic              pop;
   logic              pc_oob;
   logic [DATA_W-1:0] rd_data;
   entry_t            head;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Ready only from registered occupancy: the entry sitting in s1 is
   // counted as already owning a FIFO slot, so no path from instr_ready.
   assign pc_ready    = reset && ((32'(fifo_count) + 32'(s1_valid)) < 32'(FIFO_DEPTH));
   assign instr_valid = reset && (fifo_count != '0);
   assign accept      = pc_valid && pc_ready;
   assign push        = s1_valid;
   assign pop         = instr_valid && instr_ready;

   // Compare wide so PCs near 2^PC_W-1 cannot alias into range.
   assign pc_oob  = 64'(pc_in) >= 64'(DEPTH);
   assign rd_data = pc_oob ? '0 : mem[pc_in[AW-1:0]];

   // program memory write port; read above sees pre-edge contents
   always_ff @(posedge clock) begin
      if (prog_we) mem[prog_addr] <= prog_data;
   end

   // read stage register and wrap-detect history
   always_ff @(posedge clock) begin
      if (!reset) begin
         s1_valid <= 1'b0;
         last_pc  <= '0;
      end else begin
         s1_valid <= accept;
         if (accept) last_pc <= pc_in;
      end
   end

   // read stage payload; only meaningful while s1_valid
   always_ff @(posedge clock) begin
      if (accept) begin
         s1_ent.data <= rd_data;
         s1_ent.pc   <= pc_in;
         s1_ent.oob  <= pc_oob;
         s1_ent.wrap <= pc_in < last_pc;
      end
   end

   // FIFO storage; slot availability is guaranteed by pc_ready
   always_ff @(posedge clock) begin
      if (push) fifo_mem[wr_ptr] <= s1_ent;
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clock) begin
      if (!reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CW'(1);
            2'b01:   fifo_count <= fifo_count - CW'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // completed output handshakes, free-running wrap
   always_ff @(posedge clock) begin
      if (!reset)   fetch_count <= '0;
      else if (pop) fetch_count <= fetch_count + 32'd1;
   end

   assign head       = fifo_mem[rd_ptr];
   assign instr_out  = head.data;
   assign instr_pc   = head.pc;
   assign instr_oob  = head.oob;
   assign instr_wrap = head.wrap;

endmodule
